// File: rtl/mult_mat_vec_mac.sv
// -----------------------------------------------------------------------------
// mult_mat_vec_mac
//
// Sequential matrix-vector multiplier: out = M x X.
// There is one multiply-accumulate lane per matrix row. All lanes step through
// the Ndata columns together, one column per clock. A complete result vector
// is registered every Ndata cycles, and the next pass follows with no idle
// cycles. There is no handshake and no enable.
//
// Optional build macro:
//   MULT_MAT_VEC_MAC_SIGNED_EN - when defined, M and X elements are treated as
//   two's-complement signed values. The accumulation and the result are then
//   two's complement. Sums wrap modulo 2^(2*Nbits) in both builds.
//
// Parameters:
//   Mdata - number of matrix rows (output elements), >= 1
//   Ndata - number of matrix columns (vector length), >= 1
//   Nbits - width of each M and X element
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset; clears the column counter, the
//           accumulators and out
//   M     - flat matrix; element (r,c) at [(r*Ndata+c)*Nbits +: Nbits]
//   X     - flat vector; element c at [c*Nbits +: Nbits]
//   out   - registered result; element r at [r*2*Nbits +: 2*Nbits]
// -----------------------------------------------------------------------------
module mult_mat_vec_mac #(
  parameter int Mdata = 4,
  parameter int Ndata = 4,
  parameter int Nbits = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [Mdata*Ndata*Nbits-1:0] M,
  input  logic [Ndata*Nbits-1:0]       X,
  output logic [Mdata*2*Nbits-1:0]     out
);

  localparam int PW = 2 * Nbits;
  localparam int KW = (Ndata > 1) ? $clog2(Ndata) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(Ndata - 1);

  logic [KW-1:0]            r_k;
  logic [PW-1:0]            r_acc [Mdata];
  logic [Mdata*PW-1:0]      r_out;

  logic                     w_first;
  logic                     w_last;
  logic [Nbits-1:0]         w_x;
  logic [PW-1:0]            w_x_ext;
  logic [Nbits-1:0]         w_m   [Mdata];
  logic [PW-1:0]            w_m_ext [Mdata];
  logic [PW-1:0]            w_prod  [Mdata];
  logic [PW-1:0]            w_sum   [Mdata];

  assign w_first = (r_k == '0);
  assign w_last  = (r_k == K_LAST);

  // Column k of X is shared by all lanes.
  always_comb begin
    w_x = X[int'(r_k)*Nbits +: Nbits];
`ifdef MULT_MAT_VEC_MAC_SIGNED_EN
    w_x_ext = {{Nbits{w_x[Nbits-1]}}, w_x};
`else
    w_x_ext = {{Nbits{1'b0}}, w_x};
`endif
  end

  // Per-row MAC. Both operands are extended to 2*Nbits before the multiply.
  // The low 2*Nbits bits of that product equal the exact product, whether
  // the operands are signed or unsigned. This lets one multiplier shape
  // serve both builds.
  always_comb begin
    for (int r = 0; r < Mdata; r++) begin
      w_m[r] = M[(r*Ndata + int'(r_k))*Nbits +: Nbits];
`ifdef MULT_MAT_VEC_MAC_SIGNED_EN
      w_m_ext[r] = {{Nbits{w_m[r][Nbits-1]}}, w_m[r]};
`else
      w_m_ext[r] = {{Nbits{1'b0}}, w_m[r]};
`endif
      w_prod[r] = w_m_ext[r] * w_x_ext;
      // Column 0 starts a fresh pass, so the previous pass's total is ignored.
      w_sum[r]  = (w_first ? '0 : r_acc[r]) + w_prod[r];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k <= '0;
    end else if (w_last) begin
      r_k <= '0;
    end else begin
      r_k <= r_k + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < Mdata; r++) begin
        r_acc[r] <= '0;
      end
    end else begin
      for (int r = 0; r < Mdata; r++) begin
        r_acc[r] <= w_sum[r];
      end
    end
  end

  // The result is captured from the final column's sum. It is not taken from
  // r_acc, so it appears on the same edge that completes the pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else if (w_last) begin
      for (int r = 0; r < Mdata; r++) begin
        r_out[r*PW +: PW] <= w_sum[r];
      end
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_mult_mat_vec_mac.sv
// -----------------------------------------------------------------------------
// tb_mult_mat_vec_mac
//
// Self-checking bench for mult_mat_vec_mac at the default size (4x4, 8 bits).
// The stimulus process pushes the expected value of out for each upcoming
// clock edge into a scoreboard queue. A monitor pops those entries on the
// falling edge and compares them with out.
// -----------------------------------------------------------------------------
module tb_mult_mat_vec_mac;

  localparam int MD = 4;
  localparam int ND = 4;
  localparam int NB = 8;

  logic                    clk;
  logic                    reset;
  logic [MD*ND*NB-1:0]     M;
  logic [ND*NB-1:0]        X;
  logic [MD*2*NB-1:0]      out;

  mult_mat_vec_mac #(.Mdata(MD), .Ndata(ND), .Nbits(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .M     (M),
    .X     (X),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rows listed as elements c3..c0; row3 is in the top 32 bits.
  localparam logic [127:0] M_DEF = {8'd1, 8'd3, 8'd5, 8'd2,
                                    8'd4, 8'd5, 8'd0, 8'd0,
                                    8'd4, 8'd3, 8'd2, 8'd1,
                                    8'd5, 8'd6, 8'd7, 8'd1};
  localparam logic [31:0]  X_DEF = {8'd1, 8'd2, 8'd1, 8'd1};
  localparam logic [63:0]  RES_DEF = {16'd14, 16'd14, 16'd13, 16'd25};
  // X goes to 0 after column 0 of a pass, so only column 0 counts:
  // M(r,0)*X(0) = 1, 1, 0, 2 for rows 0..3.
  localparam logic [63:0]  RES_MIX = {16'd2, 16'd0, 16'd1, 16'd1};
  localparam logic [63:0]  RES_WRAP = {4{16'd63492}};
`ifdef MULT_MAT_VEC_MAC_SIGNED_EN
  localparam logic [63:0]  RES_NEG = {4{16'hFFFB}};
`else
  localparam logic [63:0]  RES_NEG = {4{16'd1275}};
`endif

  typedef struct {
    int unsigned cyc;
    logic [63:0] val;
    string       nm;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: out=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: out only changes on the rising edge, so compare on the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.cyc != cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: entry for cyc %0d was not compared until cyc %0d", e.nm, e.cyc, cyc);
      end else begin
        check(e.nm, out, e.val);
      end
    end
  end

  // Advance one edge. If chk is set, expect out == v after that edge.
  task automatic step(input string nm, input logic [63:0] v, input bit chk);
    if (chk) sb_q.push_back('{cyc + 1, v, nm});
    @(negedge clk);
  endtask

  task automatic restart(input logic [127:0] m, input logic [31:0] x);
    reset = 1'b1;
    step("rst_hold", 64'd0, 1'b1);
    M = m;
    X = x;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    M = M_DEF;
    X = X_DEF;
    @(negedge clk);

    // Reset held with nonzero operands.
    repeat (3) step("rst_hold", 64'd0, 1'b1);

    // Default product, latency and steady repetition.
    reset = 1'b0;
    repeat (3) step("latency", 64'd0, 1'b1);
    repeat (8) step("default", RES_DEF, 1'b1);

    // Asynchronous reset between clock edges clears out immediately.
    #2 reset = 1'b1;
    #1 check("async_clr", out, 64'd0);
    @(negedge clk);
    repeat (2) step("rst_hold", 64'd0, 1'b1);

    // X goes to 0 after column 0 of the second pass.
    reset = 1'b0;
    repeat (3) step("latency2", 64'd0, 1'b1);
    step("default2", RES_DEF, 1'b1);
    step("default2", RES_DEF, 1'b1);
    X = '0;
    repeat (2) step("hold_pre_mix", RES_DEF, 1'b1);
    repeat (4) step("mixed_pass", RES_MIX, 1'b1);
    repeat (4) step("x_zero", 64'd0, 1'b1);

    // Unsigned wrap at full scale.
    restart({16{8'hFF}}, {4{8'hFF}});
    repeat (3) step("latency_wrap", 64'd0, 1'b1);
    repeat (4) step("wrap", RES_WRAP, 1'b1);

    // Reset asserted at k=2 discards the partial sums.
    restart(M_DEF, X_DEF);
    repeat (2) step("pre_midrst", 64'd0, 1'b1);
    reset = 1'b1;
    repeat (2) step("midrst_hold", 64'd0, 1'b1);
    reset = 1'b0;
    repeat (3) step("midrst_lat", 64'd0, 1'b1);
    repeat (4) step("midrst_res", RES_DEF, 1'b1);

    // All -1 (0xFF) matrix: signedness depends on the build.
    restart({16{8'hFF}}, X_DEF);
    repeat (3) step("latency_neg", 64'd0, 1'b1);
    repeat (4) step("neg_m", RES_NEG, 1'b1);

    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish by 100000, expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
